pc_fetch_unit: RTL



---
 rtl/pc_fetch_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter at the head of fetch: boot/run/halt control, redirect select, fetch request.
// Latency: redirect or increment visible on pc_o one cycle after the deciding edge; req_valid_o is combinational from state.
// Backpressure: pc_o and req_valid_o hold while req_ready_i is low or stall_i is high; traps override both.
module pc_fetch_unit #(
    parameter int unsigned         PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned         INCREMENT    = 4,
    parameter int unsigned         ALIGN_BITS   = 2,
    parameter int unsigned         COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_reset_i,
    input  logic                   halt_i,
    input  logic                   stall_i,
    input  logic                   trap_valid_i,
    input  logic [PC_WIDTH-1:0]    trap_target_i,
    input  logic                   branch_valid_i,
    input  logic [PC_WIDTH-1:0]    branch_target_i,
    input  logic                   req_ready_i,
    output logic                   req_valid_o,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic [PC_WIDTH-1:0]    pc_next_seq_o,
    output logic                   misaligned_o,
    output logic [1:0]             state_o,
    output logic [COUNT_WIDTH-1:0] fetch_count_o
);

    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    // Low bits a legal PC must keep at zero; redirect targets are cleared with this mask.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(INCREMENT);

    // Parameter sanity: a bad combination stops elaboration rather than producing odd addresses.
    if (PC_WIDTH <= ALIGN_BITS) begin : g_bad_width
        $error("pc_fetch_unit: PC_WIDTH must exceed ALIGN_BITS");
    end
    if ((INCREMENT % (1 << ALIGN_BITS)) != 0) begin : g_bad_increment
        $error("pc_fetch_unit: INCREMENT must be a multiple of 2**ALIGN_BITS");
    end
    if ((RESET_VECTOR & ALIGN_MASK) != '0) begin : g_bad_reset_vector
        $error("pc_fetch_unit: RESET_VECTOR must be aligned");
    end

    logic [1:0]             state_q, state_n;
    logic [PC_WIDTH-1:0]    pc_q, pc_n;
    logic                   mis_q, mis_n;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                   fire;

    assign req_valid_o   = (state_q == RUN);
    assign fire          = req_valid_o & req_ready_i & ~stall_i;
    assign pc_o          = pc_q;
    assign pc_next_seq_o = pc_q + STEP;
    assign misaligned_o  = mis_q;
    assign state_o       = state_q;
    assign fetch_count_o = cnt_q;

    // Next PC / state by fixed priority: soft reset, trap, branch, halt, fire, hold.
    always_comb begin
        pc_n    = pc_q;
        mis_n   = 1'b0;
        // BOOT lasts exactly one cycle unless something below overrides it.
        state_n = (state_q == BOOT) ? RUN : state_q;
        if (soft_reset_i) begin
            pc_n    = RESET_VECTOR;
            state_n = BOOT;
        end else if (trap_valid_i) begin
            pc_n    = trap_target_i & ~ALIGN_MASK;
            mis_n   = |(trap_target_i & ALIGN_MASK);
            state_n = RUN;
        end else if (branch_valid_i && (state_q != HALTED)) begin
            pc_n    = branch_target_i & ~ALIGN_MASK;
            mis_n   = |(branch_target_i & ALIGN_MASK);
            state_n = RUN;
        end else if (halt_i && (state_q == RUN)) begin
            // A fire in this cycle is still counted, but the PC does not advance.
            state_n = HALTED;
        end else if (fire) begin
            pc_n    = pc_q + STEP;
        end
    end

    // PC, state and misalignment pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            state_q <= BOOT;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_n;
            state_q <= state_n;
            mis_q   <= mis_n;
        end
    end

    // Accepted-fetch counter; a fire squashed by a redirect or halt is still an accepted fetch.
    always_ff @(posedge clk) begin
        if (rst || soft_reset_i) begin
            cnt_q <= '0;
        end else if (fire) begin
            cnt_q <= cnt_q + COUNT_WIDTH'(1);
        end
    end

endmodule
